// File: rtl/mux16_rr_arbiter.sv
// mux16_rr_arbiter: round-robin arbiter that shares a 16:1 mux between 16 requesters.
//
// Ports:
//   clk   - clock, all state updates on the rising edge
//   rst   - synchronous reset, active-high
//   ena   - arbitration enable; low blocks new grants but never revokes a current one
//   req   - request vector, req[i] high = requester i wants the mux
//   gnt   - registered one-hot grant, zero when idle
//   sel   - registered binary index of the grantee, drives the mux select
//   valid - high while a grant is active (equals |gnt)
//
// MAX_HOLD bounds consecutive grant cycles while others wait (0 = unlimited).
// CW is the hold-counter width and must satisfy MAX_HOLD < 2**CW.

module mux16_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned CW       = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic [15:0] req,
    output logic [15:0] gnt,
    output logic [3:0]  sel,
    output logic        valid
);

    localparam logic [CW-1:0] HoldLim = CW'(MAX_HOLD);

    typedef enum logic [0:0] {StIdle, StBusy} st_e;

    st_e            st_q, st_d;
    logic [3:0]     ptr_q, ptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [15:0]    gnt_q, gnt_d;
    logic [3:0]     sel_q, sel_d;
    logic           valid_q, valid_d;

    logic           release_now;
    logic           timeout;
    logic [3:0]     next_ptr;
    logic [3:0]     win;

    // First set bit of mask scanning base, base+1, ... with 4-bit wraparound.
    function automatic logic [3:0] pick(input logic [15:0] mask, input logic [3:0] base);
        logic [3:0] idx;
        logic       found;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < 16; i++) begin
            idx = base + 4'(i);
            if (!found && mask[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    endfunction

    always_comb begin
        st_d    = st_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        valid_d = valid_q;

        // sel_q is the current grantee whenever st_q is StBusy.
        timeout     = (MAX_HOLD != 0) && (cnt_q == HoldLim) && req[sel_q];
        release_now = !req[sel_q] || timeout;
        next_ptr    = sel_q + 4'd1;
        // On release the scan starts just past the old grantee in the same edge.
        win         = pick(req, (st_q == StBusy) ? next_ptr : ptr_q);

        unique case (st_q)
            StIdle: begin
                gnt_d   = '0;
                valid_d = 1'b0;
                if (ena && (req != '0)) begin
                    st_d    = StBusy;
                    sel_d   = win;
                    gnt_d   = 16'd1 << win;
                    valid_d = 1'b1;
                    cnt_d   = CW'(1);
                end
            end
            StBusy: begin
                if (release_now) begin
                    ptr_d = next_ptr;
                    if (ena && (req != '0)) begin
                        sel_d = win;
                        gnt_d = 16'd1 << win;
                        cnt_d = CW'(1);
                    end else begin
                        st_d    = StIdle;
                        gnt_d   = '0;
                        valid_d = 1'b0;
                    end
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q    <= StIdle;
            ptr_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            st_q    <= st_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
        end
    end

    assign gnt   = gnt_q;
    assign sel   = sel_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Scoreboard bench for mux16_rr_arbiter: the driver applies inputs on the falling edge and
// pushes the reference model's post-edge outputs; the monitor checks them after each rising edge.

module tb_mux16_rr_arbiter;

    localparam int MaxHold = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ena = 1'b0;
    logic [15:0] req = '0;
    logic [15:0] gnt;
    logic [3:0]  sel;
    logic        valid;

    mux16_rr_arbiter #(
        .MAX_HOLD (MaxHold),
        .CW       (4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .ena   (ena),
        .req   (req),
        .gnt   (gnt),
        .sel   (sel),
        .valid (valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] gnt;
        logic [3:0]  sel;
        logic        valid;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    bit   done   = 1'b0;

    // Reference model: who owns the mux, how long it has held it, where priority starts.
    bit   m_busy  = 1'b0;
    int   m_owner = 0;
    int   m_ptr   = 0;
    int   m_held  = 0;
    int   m_sel   = 0;

    function automatic int rr_pick(logic [15:0] m, int start);
        for (int i = 0; i < 16; i++) begin
            if (m[(start + i) % 16]) return (start + i) % 16;
        end
        return -1;
    endfunction

    function automatic void m_grant(int who);
        m_busy  = 1'b1;
        m_owner = who;
        m_sel   = who;
        m_held  = 1;
    endfunction

    function automatic void model_edge(logic r, logic e, logic [15:0] rq);
        if (r) begin
            m_busy = 1'b0;
            m_ptr  = 0;
            m_held = 0;
            m_sel  = 0;
        end else if (!m_busy) begin
            if (e && rq != 0) m_grant(rr_pick(rq, m_ptr));
        end else begin
            if (!rq[m_owner] || (MaxHold != 0 && m_held == MaxHold)) begin
                m_ptr = (m_owner + 1) % 16;
                if (e && rq != 0) m_grant(rr_pick(rq, m_ptr));
                else m_busy = 1'b0;
            end else begin
                m_held++;
            end
        end
    endfunction

    task automatic step(input logic r, input logic e, input logic [15:0] rq, input string tag);
        exp_t x;
        @(negedge clk);
        rst = r;
        ena = e;
        req = rq;
        model_edge(r, e, rq);
        x.gnt   = m_busy ? (16'd1 << m_owner) : 16'd0;
        x.sel   = 4'(m_sel);
        x.valid = m_busy;
        x.tag   = tag;
        exp_q.push_back(x);
    endtask

    task automatic repeat_step(input int n, input logic r, input logic e, input logic [15:0] rq,
                               input string tag);
        for (int i = 0; i < n; i++) step(r, e, rq, tag);
    endtask

    // Driver
    initial begin
        logic [15:0] rq;
        repeat_step(2, 1'b1, 1'b1, 16'hFFFF, "reset_hold");
        repeat_step(3, 1'b0, 1'b1, 16'hFFFF, "after_reset");
        repeat_step(2, 1'b0, 1'b1, 16'h0000, "drain");

        repeat_step(5, 1'b0, 1'b1, 16'h0020, "single_req");
        repeat_step(2, 1'b0, 1'b1, 16'h0000, "single_drop");

        repeat_step(20, 1'b0, 1'b1, 16'h8001, "timeout_fair");
        repeat_step(1, 1'b0, 1'b1, 16'h0000, "drain");

        repeat_step(2, 1'b0, 1'b1, 16'h0020, "rot_grant5");
        repeat_step(1, 1'b0, 1'b1, 16'h0000, "rot_release5");
        repeat_step(2, 1'b0, 1'b1, 16'h0021, "rot_pick0");
        repeat_step(2, 1'b0, 1'b1, 16'h0020, "rot_pick5");
        repeat_step(1, 1'b0, 1'b1, 16'h0000, "drain");

        repeat_step(2, 1'b0, 1'b0, 16'h0100, "ena_low");
        repeat_step(2, 1'b0, 1'b1, 16'h0100, "ena_high");
        repeat_step(3, 1'b0, 1'b0, 16'h0200, "ena_block");
        repeat_step(2, 1'b0, 1'b1, 16'h0200, "ena_resume");
        repeat_step(1, 1'b0, 1'b1, 16'h0000, "drain");

        repeat_step(2, 1'b0, 1'b1, 16'h0100, "mid_grant");
        repeat_step(1, 1'b1, 1'b1, 16'h0101, "mid_reset");
        repeat_step(2, 1'b0, 1'b1, 16'h0101, "post_reset");

        rq = 16'h0000;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(3) == 0) begin
                if ($urandom_range(1) == 0) rq = 16'($urandom) & 16'($urandom) & 16'($urandom);
                else rq = 16'd1 << $urandom_range(15);
            end
            step(($urandom_range(63) == 0), ($urandom_range(7) != 0), rq, "random");
        end
        done = 1'b1;
    end

    // Monitor
    initial begin
        exp_t x;
        wait (exp_q.size() != 0);
        while (!(done && exp_q.size() == 0)) begin
            @(posedge clk);
            #1;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_miss++;
                $display("FAIL no_expect: got gnt=%h sel=%0d valid=%b, required a queued vector",
                         gnt, sel, valid);
            end else begin
                x = exp_q.pop_front();
                if (gnt !== x.gnt || sel !== x.sel || valid !== x.valid) begin
                    n_miss++;
                    $display("FAIL %s @%0t: got gnt=%h sel=%0d valid=%b, required gnt=%h sel=%0d valid=%b",
                             x.tag, $time, gnt, sel, valid, x.gnt, x.sel, x.valid);
                end
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
